// File: rtl/booth_divider.sv
// Sequential signed 16/8 divider: restoring division on magnitudes over 16 cycles,
// then a single sign-correction cycle that also flags quotient overflow.
module booth_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] p,
    input  logic [7:0]  y,
    output logic        busy,
    output logic        done,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf,
    output logic        dz
);

    localparam int unsigned PW = 16;
    localparam int unsigned YW = 8;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] dvd_q, dvd_d;
    logic [YW-1:0] dvs_q, dvs_d;
    logic [YW-1:0] rem_q, rem_d;
    logic          sq_q, sq_d;
    logic          sr_q, sr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [YW-1:0] q_q, q_d;
    logic [YW-1:0] r_q, r_d;
    logic          ovf_q, ovf_d;
    logic          dz_q, dz_d;

    logic [YW:0]   shifted;
    logic [PW-1:0] q_signed;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        sq_d     = sq_q;
        sr_d     = sr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        q_d      = q_q;
        r_d      = r_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        shifted  = {rem_q, dvd_q[PW-1]};
        q_signed = sq_q ? PW'(~dvd_q + 16'd1) : dvd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (y == '0) begin
                        q_d    = '0;
                        r_d    = '0;
                        ovf_d  = 1'b0;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sq_d    = p[PW-1] ^ y[YW-1];
                        sr_d    = p[PW-1];
                        dvd_d   = p[PW-1] ? PW'(~p + 16'd1) : p;
                        dvs_d   = y[YW-1] ? YW'(~y + 8'd1) : y;
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Trial subtract; the remainder always fits in 8 bits since it stays below |y|
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d = YW'(shifted - {1'b0, dvs_q});
                    dvd_d = {dvd_q[PW-2:0], 1'b1};
                end else begin
                    rem_d = shifted[YW-1:0];
                    dvd_d = {dvd_q[PW-2:0], 1'b0};
                end
                cnt_d = CW'(cnt_q + 4'd1);
                if (cnt_q == 4'd15) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                ovf_d   = sq_q ? (dvd_q > 16'd128) : (dvd_q > 16'd127);
                q_d     = q_signed[YW-1:0];
                r_d     = sr_q ? YW'(~rem_q + 8'd1) : rem_q;
                dz_d    = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule
